multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle RISC-V control unit: a Moore FSM that sequences one instruction over 3–5 cycles through a shared-memory, single-ALU datapath. It supports variable-latency memory through a request/ready handshake, an optional wait-state timeout, and an optional retired-instruction counter. It decodes the RV32I subset R/I-ALU, lw, sw, beq/bne/blt/bge, jal, jalr, lui and auipc, and drives every datapath mux, write enable and ALU operation.

## Interface
- TIMEOUT, 0, maximum cycles a memory state waits for mem_ready; 0 disables the timeout.
- CNT_W, 32, width of instret.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  from instruction register.
- funct3  in  3  from instruction register.
- funct7  in  7  from instruction register.
- zero  in  1  ALU zero flag, combinational from current ALU result.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  write qualifier for mem_req.
- AdrSrc  out  1  address select: 0=PC, 1=ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  register-file write.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1, 11=zero.
- ALUSrcB  out  2  00=RD2, 01=Imm, 10=constant 4.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded from opcode every cycle.
- illegal  out  1  sticky; core halted.
- instret  out  CNT_W  retired-instruction count; only with the macro.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, EXECU, ALUWB, BRANCH, JAL, JALRA, JALRPC, ERROR.
- Default outputs are all 0 (ALUControl=add). Only the differences are listed below.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcB=10, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Go to DECODE when mem_ready=1, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0110111 or 0010111 → EXECU
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALRA
  - anything else → ERROR
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMRD for loads, MEMWR for stores.
- MEMRD: mem_req=1, AdrSrc=1. Go to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWR: mem_req=1, MemWrite=1, AdrSrc=1. Go to FETCH on mem_ready.
- EXECR / EXECI: ALUSrcA=10; ALUSrcB=00 for EXECR, 01 for EXECI. Go to ALUWB.
  - ALUControl by funct3: 000 add (sub if EXECR and funct7[5]=1), 010 slt, 100 xor, 110 or, 111 and.
  - Any other funct3 → ERROR instead of ALUWB.
- EXECU: ALUSrcA=11 for lui, 01 for auipc; ALUSrcB=01, add. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00.
  - ALUControl=sub for funct3 000/001, slt for 100/101.
  - Taken condition: beq zero; bne !zero; blt !zero; bge zero. PCWrite = taken.
  - funct3 010/011/110/111 → ERROR with PCWrite=0; otherwise go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. Go to ALUWB (writes OldPC+4).
- JALRA: ALUSrcA=10, ALUSrcB=01, add. Go to JALRPC.
- JALRPC: identical outputs to JAL. Go to ALUWB.
- ERROR: all strobes 0, illegal=1. Left only by reset.
- Timeout, when TIMEOUT>0:
  - A wait counter clears on entering FETCH, MEMRD or MEMWR and increments each cycle mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0, go to ERROR.
  - mem_ready=1 in that same cycle wins.

## Timing
- Reset (async assert, state=FETCH, counters=0):
  - While rst_n=0, mem_req, IRWrite, PCWrite, RegWrite, MemWrite and illegal are forced to 0.
  - First request occurs in the first cycle after rst_n deasserts.
  - Reset mid-instruction abandons it with no write strobes.
- Outputs are Moore, from registered state, except two Mealy terms:
  - the FETCH mem_ready gating;
  - the BRANCH PCWrite.
- Zero-wait-state cycle counts: R/I/U-type 4, lw 5, sw 4, branch 3, jal 4, jalr 5. Each cycle mem_ready=0 in a memory state adds one.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

## Configuration
- RV_CTRL_INSTRET_EN defined:
  - instret port exists.
  - Increments (wrapping at 2^CNT_W) on the final cycle of every instruction: MEMWB, MEMWR with mem_ready, ALUWB, BRANCH without error.
  - Never counts in ERROR.
- Undefined: no instret port, no counter logic.

## Test plan
- addi x1,x0,5 with mem_ready always 1 → FETCH, DECODE, EXECI, ALUWB. RegWrite=1 only in cycle 4; ALUControl=000; instret 0→1.
- lw with mem_ready low 2 cycles in MEMRD → 7 total cycles; MemWrite stays 0; RegWrite with ResultSrc=01 for exactly one cycle.
- bne, zero=0 → PCWrite=1 in BRANCH. bge, zero=0 → PCWrite=0. Both take 3 cycles.
- opcode 0000000, or funct3=011 on R-type → illegal=1 after DECODE or EXEC. Strobes stay 0 for 20 cycles until rst_n pulses low.
- TIMEOUT=4, mem_ready held 0 in FETCH → ERROR after 4 waiting cycles. Repeat with mem_ready=1 on cycle 4 → normal DECODE.
- rst_n asserted during MEMWR → all strobes 0 immediately. After release, FETCH with mem_req=1; instret=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: Moore FSM driving a shared-memory, single-ALU datapath.
// Optional retired-instruction counter enabled by defining RV_CTRL_INSTRET_EN.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE  | OldPC+imm into ALUOut (branch/jal target), dispatch on opcode
// MEMADR  | RD1+imm -> ALUOut as load/store address
// MEMRD   | load data read, waits on mem_ready
// MEMWB   | load data written to rd
// MEMWR   | store write, waits on mem_ready
// EXECR   | RD1 op RD2
// EXECI   | RD1 op imm
// EXECU   | lui (0+imm) / auipc (OldPC+imm)
// ALUWB   | ALUOut written to rd
// BRANCH  | compare, PC <= target if taken
// JAL     | PC <= target, OldPC+4 -> ALUOut
// JALRA   | RD1+imm -> ALUOut
// JALRPC  | PC <= ALUOut, OldPC+4 -> ALUOut
// ERROR   | halted, left only by reset
module multicycle_controller #(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       ImmSrc,
    output logic             illegal
`ifdef RV_CTRL_INSTRET_EN
    ,
    output logic [CNT_W-1:0] instret
`endif
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
        S_EXECU, S_ALUWB, S_BRANCH, S_JAL, S_JALRA, S_JALRPC, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_state;
    logic              timeout_hit;
    logic              retire;
    logic              mem_req_raw, mem_write_raw, ir_write_raw, pc_write_raw;
    logic              reg_write_raw, illegal_raw;

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A ready in the last allowed cycle still completes the access.
    assign timeout_hit = (TIMEOUT > 0) && !mem_ready && (wait_q == WAIT_LAST);

    always_comb begin
        ImmSrc = 3'b000;
        case (opcode)
            OP_STORE:          ImmSrc = 3'b001;
            OP_BR:             ImmSrc = 3'b010;
            OP_JAL:            ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
            default:           ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        retire        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                if (mem_ready)        state_d = S_DECODE;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_LUI, OP_AUIPC:  state_d = S_EXECU;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALRA;
                    default:           state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_raw = 1'b1;
                AdrSrc      = 1'b1;
                if (mem_ready)        state_d = S_MEMWB;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_raw   = 1'b1;
                mem_write_raw = 1'b1;
                AdrSrc        = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                state_d = S_ALUWB;
                case (funct3)
                    3'b000:  ALUControl = (state_q == S_EXECR && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: state_d = S_ERROR;
                endcase
            end
            S_EXECU: begin
                ALUSrcA = (opcode == OP_LUI) ? 2'b11 : 2'b01;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                retire  = 1'b1;
                state_d = S_FETCH;
                // blt/bge use slt: zero flag set means rs1 >= rs2
                case (funct3)
                    3'b000: begin ALUControl = ALU_SUB; pc_write_raw = zero;  end
                    3'b001: begin ALUControl = ALU_SUB; pc_write_raw = !zero; end
                    3'b100: begin ALUControl = ALU_SLT; pc_write_raw = !zero; end
                    3'b101: begin ALUControl = ALU_SLT; pc_write_raw = zero;  end
                    default: begin
                        retire  = 1'b0;
                        state_d = S_ERROR;
                    end
                endcase
            end
            S_JAL, S_JALRPC: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_ALUWB;
            end
            S_JALRA: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JALRPC;
            end
            S_ERROR: begin
                illegal_raw = 1'b1;
            end
            default: state_d = S_ERROR;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if ((TIMEOUT > 0) && mem_state && !mem_ready)
            wait_d = wait_q + WAIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Strobes are held low for the whole reset pulse, not just from the next edge.
    assign mem_req  = rst_n & mem_req_raw;
    assign MemWrite = rst_n & mem_write_raw;
    assign IRWrite  = rst_n & ir_write_raw;
    assign PCWrite  = rst_n & pc_write_raw;
    assign RegWrite = rst_n & reg_write_raw;
    assign illegal  = rst_n & illegal_raw;

`ifdef RV_CTRL_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_q <= '0;
        else if (retire)
            instret_q <= instret_q + CNT_W'(1);
    end

    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule
